// File: rtl/ssd_scan_mux.sv
// Time-multiplexed scan controller for common-anode seven-segment digits with a
// per-slot dead time and a frame-synchronous display buffer. Define SSD_SCAN_MUX_LZS_EN for leading-zero suppression.
module ssd_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    ssd_scan_mux_port_clk,
    input  logic                    ssd_scan_mux_port_rst_n,
    input  logic [4*NUM_DIGITS-1:0] ssd_scan_mux_port_value,
    input  logic                    ssd_scan_mux_port_load,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_mux_port_blank,
    output logic [3:0]              ssd_scan_mux_port_nibble,
    output logic [NUM_DIGITS-1:0]   ssd_scan_mux_port_an,
    output logic [IDX_W-1:0]        ssd_scan_mux_port_idx,
    output logic                    ssd_scan_mux_port_frame
);

    localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int                DW       = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  DEAD_V   = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         staging_q, staging_d;
    logic                  pending_q, pending_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  slot_end;
    logic                  boundary;
    logic                  lit_window;
    logic [3:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] blank_eff;

    assign slot_end = (cnt_q == CNT_LAST);
    assign boundary = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shadow only changes on the frame boundary so a frame never mixes two values;
    // a load landing on the boundary itself bypasses staging.
    always_comb begin
        staging_d = staging_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        if (ssd_scan_mux_port_load) begin
            staging_d = ssd_scan_mux_port_value;
            pending_d = 1'b1;
        end
        if (boundary) begin
            if (ssd_scan_mux_port_load) begin
                shadow_d  = ssd_scan_mux_port_value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                shadow_d  = staging_q;
                pending_d = 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi] = shadow_d[4*gi +: 4];
        end
    endgenerate

`ifdef SSD_SCAN_MUX_LZS_EN
    // Walk down from the top digit; everything above the first nonzero digit is dark.
    logic seen_nz;
    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (digit[k] != 4'h0) begin
                seen_nz = 1'b1;
            end
            if (!seen_nz) begin
                lz_mask[k] = 1'b1;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign blank_eff  = ssd_scan_mux_port_blank | lz_mask;
    assign lit_window = (cnt_d >= DEAD_V);

    // Output registers are computed from next-state so they line up with cnt_q/idx_q.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_d[gi] = ~((idx_d == IDX_W'(gi)) && lit_window && !blank_eff[gi]);
        end
    endgenerate

    assign nibble_d = digit[idx_d];
    assign frame_d  = boundary;

    always_ff @(posedge ssd_scan_mux_port_clk or negedge ssd_scan_mux_port_rst_n) begin
        if (!ssd_scan_mux_port_rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            staging_q <= '0;
            pending_q <= 1'b0;
            nibble_q  <= 4'h0;
            an_q      <= '1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            staging_q <= staging_d;
            pending_q <= pending_d;
            nibble_q  <= nibble_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign ssd_scan_mux_port_nibble = nibble_q;
    assign ssd_scan_mux_port_an     = an_q;
    assign ssd_scan_mux_port_idx    = idx_q;
    assign ssd_scan_mux_port_frame  = frame_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux: the stimulus queues the expected per-cycle outputs,
// and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ssd_scan_mux;

    localparam int N = 4;
    localparam int R = 8;
    localparam int D = 2;
`ifdef SSD_SCAN_MUX_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  idx;
    logic        frame;

    always #5 clk = ~clk;

    ssd_scan_mux #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .DEAD_CYCLES(D)
    ) dut (
        .ssd_scan_mux_port_clk   (clk),
        .ssd_scan_mux_port_rst_n (rst_n),
        .ssd_scan_mux_port_value (value),
        .ssd_scan_mux_port_load  (load),
        .ssd_scan_mux_port_blank (blank),
        .ssd_scan_mux_port_nibble(nibble),
        .ssd_scan_mux_port_an    (an),
        .ssd_scan_mux_port_idx   (idx),
        .ssd_scan_mux_port_frame (frame)
    );

    typedef struct {
        logic [1:0] idx;
        logic [3:0] an;
        logic [3:0] nibble;
        logic       frame;
        int         tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    int          t        = 0;
    logic [15:0] exp_shadow;
    logic [3:0]  exp_lz;

    // Expected outputs after tt edges since reset release, for a given displayed value.
    function automatic exp_t expect_at(int tt, logic [15:0] sh, logic [3:0] bl, logic [3:0] lz);
        exp_t e;
        int   c;
        int   k;
        c        = tt % R;
        k        = (tt / R) % N;
        e.idx    = 2'(k);
        e.an     = 4'hF;
        if (c >= D && !bl[k] && !lz[k]) e.an[k] = 1'b0;
        e.nibble = sh[4*k +: 4];
        e.frame  = (tt > 0) && (tt % (N * R) == 0);
        e.tag    = tt;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.idx    = 2'd0;
        e.an     = 4'hF;
        e.nibble = 4'h0;
        e.frame  = 1'b0;
        e.tag    = -1;
        return e;
    endfunction

    task automatic step(input bit do_push);
        @(posedge clk);
        #1;
        t++;
        if (do_push) exp_q.push_back(expect_at(t, exp_shadow, blank, exp_lz));
    endtask

    task automatic run_to(input int n);
        while (t < n) step(1'b1);
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step(1'b1);
        load  = 1'b0;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp, input int tag);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d t=%0d idx=%0d an=%b nibble=%h frame=%b", n_txn, e.tag, idx, an, nibble, frame);
            check("idx",    {2'b00, idx},   {2'b00, e.idx},   e.tag);
            check("an",     an,             e.an,             e.tag);
            check("nibble", nibble,         e.nibble,         e.tag);
            check("frame",  {3'b000, frame}, {3'b000, e.frame}, e.tag);
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = 16'h0;
        blank      = 4'b0000;
        exp_shadow = 16'h0000;
        exp_lz     = LZS ? 4'b1110 : 4'b0000;

        repeat (2) begin
            @(posedge clk);
            #1;
            exp_q.push_back(reset_exp());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t     = 0;

        // Frame 0 shows 0; load mid-frame becomes visible at the boundary.
        run_to(4);
        do_load(16'h1234);
        run_to(31);
        exp_shadow = 16'h1234;
        exp_lz     = 4'b0000;
        // Two loads in frame 1: the last one wins.
        run_to(40);
        do_load(16'h5555);
        run_to(50);
        do_load(16'hABCD);
        run_to(63);
        exp_shadow = 16'hABCD;
        // Load issued in the very cycle of the 3->0 wrap.
        run_to(95);
        exp_shadow = 16'h00F0;
        exp_lz     = LZS ? 4'b1100 : 4'b0000;
        do_load(16'h00F0);
        // Blank digits 0 and 2 for one whole frame.
        run_to(127);
        blank = 4'b0101;
        run_to(159);
        blank = 4'b0000;
        // Reset in slot 2 at cnt=5, checked before any further clock edge.
        run_to(180);
        step(1'b0);
        #1;
        rst_n = 1'b0;
        exp_q.push_back(reset_exp());
        repeat (2) begin
            @(posedge clk);
            #1;
            exp_q.push_back(reset_exp());
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        t          = 0;
        exp_shadow = 16'h0000;
        exp_lz     = LZS ? 4'b1110 : 4'b0000;

        run_to(4);
        do_load(16'h0070);
        run_to(31);
        exp_shadow = 16'h0070;
        exp_lz     = LZS ? 4'b1100 : 4'b0000;
        run_to(40);
        do_load(16'h0000);
        run_to(63);
        exp_shadow = 16'h0000;
        exp_lz     = LZS ? 4'b1110 : 4'b0000;
        run_to(72);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
